// File: rtl/write_back_unit.sv
// ============================================================================
// write_back_unit : MEM/WB pipeline register, 8x16 register file with
//                   WB-bypassed read ports and a committed-write counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module write_back_unit #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W+REG_ADDR_W:0]  mem_in,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [REG_ADDR_W-1:0]       rd_addr1,
  input  logic [REG_ADDR_W-1:0]       rd_addr2,
  output logic [DATA_W-1:0]           rd_data1,
  output logic [DATA_W-1:0]           rd_data2,
  output logic [DATA_W-1:0]           wb_data,
  output logic [REG_ADDR_W-1:0]       wb_addr,
  output logic                        wb_we,
  output logic [15:0]                 retire_count
);

  localparam int WE_BIT = DATA_W + REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;

  // The WB entry retires on the edge where it leaves the stage.
  assign commit = wb_we && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      retire_count <= '0;
      wb_we        <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
    end else begin
      if (commit) begin
        regs[wb_addr] <= wb_data;
        retire_count  <= retire_count + 16'd1;
      end
      if (!stall) begin
        if (flush) begin
          wb_we   <= 1'b0;
          wb_addr <= '0;
          wb_data <= '0;
        end else begin
          wb_we   <= mem_in[WE_BIT];
          wb_addr <= mem_in[WE_BIT-1:DATA_W];
          wb_data <= mem_in[DATA_W-1:0];
        end
      end
    end
  end

  // Youngest value wins: the uncommitted WB entry overrides the register file.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
    if (wb_we && (wb_addr == rd_addr1)) begin
      rd_data1 = wb_data;
    end
    if (wb_we && (wb_addr == rd_addr2)) begin
      rd_data2 = wb_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_write_back_unit.sv
// ============================================================================
// tb_write_back_unit : scoreboard bench for write_back_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_write_back_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] mem_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  rd_addr1 = '0;
  logic [2:0]  rd_addr2 = '0;
  logic [15:0] rd_data1, rd_data2, wb_data, retire_count;
  logic [2:0]  wb_addr;
  logic        wb_we;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_regs [8];
  logic        m_we;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] m_count;

  localparam logic [19:0] BUBBLE = {1'b0, 3'd5, 16'hDEAD};

  write_back_unit #(.DATA_W(16), .REG_ADDR_W(3), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst), .mem_in(mem_in), .stall(stall), .flush(flush),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_we = 1'b0; m_addr = '0; m_data = '0; m_count = '0;
  endfunction

  function automatic void model_edge(input logic st, input logic fl, input logic [19:0] min);
    if (m_we && !st) begin
      m_regs[m_addr] = m_data;
      m_count        = m_count + 16'd1;
    end
    if (!st) begin
      if (fl) {m_we, m_addr, m_data} = '0;
      else    {m_we, m_addr, m_data} = min;
    end
  endfunction

  // Drive one cycle, push the expected post-edge state, then pop and compare.
  task automatic cycle(input logic st, input logic fl, input logic [19:0] min);
    exp_t e;
    stall = st; flush = fl; mem_in = min;
    model_edge(st, fl, min);
    exp_q.push_back({m_we, m_addr, m_data, m_count});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({wb_we, wb_addr, wb_data, retire_count} !== {e.we, e.addr, e.data, e.cnt}) begin
      failures++;
      $display("FAIL wb_state: got we=%0b addr=%0d data=%h cnt=%h, want we=%0b addr=%0d data=%h cnt=%h",
               wb_we, wb_addr, wb_data, retire_count, e.we, e.addr, e.data, e.cnt);
    end
  endtask

  task automatic check_rd(input logic [2:0] a1, input logic [2:0] a2);
    logic [15:0] e1, e2;
    rd_addr1 = a1; rd_addr2 = a2; #1;
    e1 = (m_we && m_addr == a1) ? m_data : m_regs[a1];
    e2 = (m_we && m_addr == a2) ? m_data : m_regs[a2];
    checks += 2;
    if (rd_data1 !== e1) begin
      failures++;
      $display("FAIL rd_port1 addr=%0d: got %h, want %h", a1, rd_data1, e1);
    end
    if (rd_data2 !== e2) begin
      failures++;
      $display("FAIL rd_port2 addr=%0d: got %h, want %h", a2, rd_data2, e2);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({wb_we, wb_addr, wb_data, retire_count} !== 36'd0) begin
      failures++;
      $display("FAIL reset_state: got we=%0b addr=%0d data=%h cnt=%h, want all 0",
               wb_we, wb_addr, wb_data, retire_count);
    end
    check_rd(3'd0, 3'd7);
  endtask

  task automatic test_write_bypass();
    cycle(1'b0, 1'b0, {1'b1, 3'd5, 16'hBEEF});
    check_rd(3'd5, 3'd0);
    checks++;
    if (rd_data1 !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_beef: got %h, want BEEF", rd_data1);
    end
    cycle(1'b0, 1'b0, BUBBLE);
    check_rd(3'd5, 3'd5);
    checks++;
    if (rd_data1 !== 16'hBEEF || retire_count !== 16'd1) begin
      failures++;
      $display("FAIL commit_beef: got data=%h cnt=%h, want BEEF cnt=0001", rd_data1, retire_count);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b0, {1'b1, 3'd2, 16'h1111});
    check_rd(3'd0, 3'd2);
    cycle(1'b0, 1'b0, {1'b1, 3'd2, 16'h2222});
    check_rd(3'd2, 3'd2);
    checks++;
    if (rd_data2 !== 16'h2222) begin
      failures++;
      $display("FAIL b2b_youngest: got %h, want 2222", rd_data2);
    end
    cycle(1'b0, 1'b0, BUBBLE);
    check_rd(3'd5, 3'd2);
  endtask

  task automatic test_stall();
    logic [15:0] cnt0;
    cycle(1'b0, 1'b0, {1'b1, 3'd7, 16'h00A5});
    cnt0 = retire_count;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, {1'b1, 3'(i), 16'($urandom)});
      check_rd(3'd7, 3'(i));
      checks++;
      if (rd_data1 !== 16'h00A5 || retire_count !== cnt0) begin
        failures++;
        $display("FAIL stall_hold: got data=%h cnt=%h, want 00A5 cnt=%h", rd_data1, retire_count, cnt0);
      end
    end
    cycle(1'b0, 1'b0, {1'b1, 3'd3, 16'h3333});
    checks++;
    if (retire_count !== cnt0 + 16'd1 || wb_addr !== 3'd3) begin
      failures++;
      $display("FAIL stall_release: got cnt=%h addr=%0d, want cnt=%h addr=3", retire_count, wb_addr, cnt0 + 16'd1);
    end
    check_rd(3'd7, 3'd3);
  endtask

  task automatic test_flush();
    logic [15:0] cnt0;
    cycle(1'b0, 1'b0, BUBBLE);
    cnt0 = retire_count;
    cycle(1'b0, 1'b1, {1'b1, 3'd1, 16'hFFFF});
    cycle(1'b0, 1'b0, BUBBLE);
    check_rd(3'd1, 3'd1);
    checks++;
    if (rd_data1 !== 16'h0000 || retire_count !== cnt0) begin
      failures++;
      $display("FAIL flush_r1: got data=%h cnt=%h, want 0000 cnt=%h", rd_data1, retire_count, cnt0);
    end
    cycle(1'b0, 1'b0, {1'b1, 3'd4, 16'h4444});
    cycle(1'b1, 1'b1, {1'b1, 3'd1, 16'hFFFF});
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 3'd4, 16'h4444}) begin
      failures++;
      $display("FAIL flush_under_stall: got we=%0b addr=%0d data=%h, want 1/4/4444", wb_we, wb_addr, wb_data);
    end
    cycle(1'b0, 1'b0, BUBBLE);
    check_rd(3'd4, 3'd1);
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, {1'b1, 3'd6, 16'h6666});
    cycle(1'b1, 1'b0, {1'b1, 3'd0, 16'h0BAD});
    #2 rst = 1'b1;
    #1;
    checks++;
    if (wb_we !== 1'b0 || retire_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_async: got we=%0b cnt=%h, want 0/0000", wb_we, retire_count);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = 3'(i); rd_addr2 = 3'(7 - i); #1;
      checks++;
      if (rd_data1 !== 16'd0 || rd_data2 !== 16'd0) begin
        failures++;
        $display("FAIL reset_regs addr=%0d: got %h/%h, want 0/0", i, rd_data1, rd_data2);
      end
    end
    stall = 1'b0; flush = 1'b0; mem_in = BUBBLE;
    model_reset();
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    cycle(1'b0, 1'b0, BUBBLE);
    cycle(1'b0, 1'b0, BUBBLE);
    check_rd(3'd6, 3'd7);
  endtask

  task automatic test_wrap();
    logic [19:0] w;
    for (int i = 0; i < 65536; i++) begin
      if (i % 4096 == 0) begin
        stall = 1'b0; flush = 1'b0; mem_in = {1'b0, 3'(i), 16'hF00D};
        model_edge(1'b0, 1'b0, mem_in);
        @(posedge clk); #1;
      end
      w = {1'b1, 3'(i), 16'(i)};
      mem_in = w;
      model_edge(1'b0, 1'b0, w);
      @(posedge clk); #1;
      if (i == 65535) begin
        checks++;
        if (retire_count !== 16'hFFFF) begin
          failures++;
          $display("FAIL wrap_ffff: got %h, want FFFF", retire_count);
        end
      end
    end
    cycle(1'b0, 1'b0, BUBBLE);
    checks++;
    if (retire_count !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_zero: got %h, want 0000", retire_count);
    end
    check_rd(3'd7, 3'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_write_bypass();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/write_back_unit.md
# write_back_unit

Final pipeline stage of the processor: the MEM/WB pipeline register, the 8 × 16-bit register file, and its two combinational read ports. It consumes the 20-bit memory-stage result bundle: 16-bit data, 3-bit destination register, and write-enable. Each instruction is committed to the register file exactly once. WB-stage contents are exported for forwarding, and a committed-write counter is kept for debug.

## Interface
- DATA_W, 16, data and register width
- REG_ADDR_W, 3, register address width
- NUM_REGS, 8, register count (2**REG_ADDR_W)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_in  input  20  memory-stage bundle: [15:0] data, [18:16] destination register, [19] write enable
- stall  input  1  hold the MEM/WB register and suppress commit this edge
- flush  input  1  load a bubble instead of mem_in (ignored while stall=1)
- rd_addr1, rd_addr2  input  3  read-port addresses (decode stage)
- rd_data1, rd_data2  output  16  read data, with WB bypass
- wb_data  output  16  data held in MEM/WB register
- wb_addr  output  3  destination held in MEM/WB register
- wb_we  output  1  write enable held in MEM/WB register (0 = bubble)
- retire_count  output  16  number of committed register writes, wraps

## Operation
- MEM/WB register fields {wb_we, wb_addr, wb_data}, updated at each edge:
  - stall=1: hold all fields; flush is ignored.
  - stall=0, flush=1: load bubble {0, 0, 0}.
  - stall=0, flush=0: load mem_in[19], mem_in[18:16], mem_in[15:0].
- Commit, evaluated on the same edge before the register updates: if wb_we=1 and stall=0, write regs[wb_addr] ← wb_data and increment retire_count.
  - This means an entry commits on the edge where it leaves WB.
  - A stalled entry commits once, on the first edge after stall falls.
- Read ports (combinational):
  - rd_dataN = wb_data when wb_we=1 and wb_addr=rd_addrN.
  - Otherwise rd_dataN = regs[rd_addrN].
  - The bypass applies whether or not stall is asserted.
  - Both ports may address the same register. All 8 registers are writable; there is no hard-wired zero register.
- retire_count: 16-bit unsigned, 0xFFFF + 1 → 0x0000, with no saturation or flag.
- A bubble (wb_we=0) never writes and never counts, regardless of wb_addr/wb_data.
- Reset, asynchronous and effective immediately, including mid-stall:
  - wb_we=0, wb_addr=0, wb_data=0.
  - All regs=0, retire_count=0.
  - rd_data1/rd_data2 therefore read 0.
  - A pending uncommitted WB entry is discarded.

## Timing
- Edge k latches an instruction from mem_in.
- During cycle k→k+1:
  - wb_* show the instruction.
  - Matching reads see its data via bypass.
- Edge k+1, if stall=0: register file written; retire_count +1.
  - From k+1 onward, reads see the value from regs.
- Latency from mem_in to architectural visibility via bypass: 1 edge; via regs: 2 edges.
- Back-to-back writes to the same register on consecutive edges: a read returns the youngest value (WB bypass overrides regs).
- The read path is combinational from rd_addrN, wb_* and regs; it has no dependency on mem_in.
- Deassertion of rst is synchronous to clk by the system; the first latch occurs on the first edge after deassertion.

## Test plan
- Reset: assert rst mid-run with regs non-zero and wb_we=1 → immediately wb_we=0, retire_count=0, rd_data1=rd_data2=0 for every address; after release, no write of the discarded entry.
- Write/bypass:
  - Drive mem_in={1,3'd5,16'hBEEF} for one edge, then a bubble.
  - With rd_addr1=5: rd_data1=BEEF in the cycle after the latch (bypass) and still BEEF after commit.
  - retire_count=1.
- Same-register back-to-back:
  - Write R2←0x1111 then R2←0x2222 on consecutive edges.
  - rd_data2 (addr 2) reads 1111, then 2222 on the next cycle (bypass over committed 1111), then 2222 from regs.
- Stall:
  - Latch {1,R7,0x00A5}, then hold stall=1 for 3 cycles while changing mem_in.
  - wb_* unchanged, bypass returns 00A5, regs[7] and retire_count unchanged.
  - On the first edge with stall=0: exactly one commit, and the new mem_in latches.
- Flush:
  - flush=1 with mem_in={1,R1,0xFFFF}: wb_we=0 next cycle, R1 never written, retire_count unchanged.
  - flush=1 together with stall=1: register holds the old entry.
- Counter wrap: 65536 committed writes (bubbles interleaved, which must not count) → retire_count returns to 0x0000.
